matrix_scan_controller: RTL
===========================

# matrix_scan_controller

Sequencer for the 7-row × 5-column LED matrix. It generates the row-scan timing with an inter-row blanking gap, owns the displayed frame index, and applies frame changes only at frame boundaries. The frame index comes from a debounced pushbutton (manual mode) or from an auto-advance timer. It drives the row lines directly and feeds `linha_idx`/`quadro` to the column multiplexer, gating that multiplexer's output through `colunas_en`.

## Interface
- `ROW_TICKS`, 50000: clock cycles per row slot (1 kHz row rate at 50 MHz); must be > `BLANK_TICKS`.
- `BLANK_TICKS`, 500: cycles at the start of each slot with all rows and columns off; must be ≥ 1.
- `DEBOUNCE_TICKS`, 500000: cycles the synchronized button level must stay stable before it is accepted (10 ms).
- `AUTO_FRAMES`, 60: full refresh frames per auto-advance step; must be ≥ 1.

Ports:
- `clock_50MHz` in 1: the only clock; all state is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `chaves` in 2: mode, asynchronous. 00 = off, 01 = manual, 10 = auto forward, 11 = auto reverse.
- `botao_n` in 1: active-low pushbutton, asynchronous, bouncing.
- `linhas` out 7: active-low one-hot row enable. Bit i drives row i.
- `linha_idx` out 3: current row, 0..6.
- `quadro` out 3: current frame, 0..7.
- `colunas_en` out 1: high enables the column drivers. Downstream forms `colunas = col & {5{colunas_en}}`.
- `frame_start` out 1: one-cycle pulse on the first cycle of each row-0 slot.

## Operation
- Reset values: `linhas`=7'h7F, `linha_idx`=0, `quadro`=0, `colunas_en`=0, `frame_start`=0. FSM=OFF, all counters and the pending flag are 0.
- `chaves` and `botao_n` each pass through a 2-FF synchronizer. `botao_n` is then debounced; an accepted 1→0 transition yields a one-cycle `press` pulse.
- FSM states:
  - OFF: rows off, `colunas_en`=0, tick and row counters held at 0.
  - BLANK: `linhas`=7'h7F, `colunas_en`=0, `linha_idx` already holds the new row.
  - SCAN: `linhas[linha_idx]`=0, `colunas_en`=1.
- Transitions:
  - OFF→BLANK when the synchronized mode ≠ 00. Entry is at row 0, and `frame_start` pulses.
  - BLANK→SCAN after `BLANK_TICKS` cycles.
  - SCAN→BLANK when the slot reaches `ROW_TICKS` total cycles. `linha_idx` increments, wrapping 6→0.
  - Any state→OFF on the cycle after the synchronized mode becomes 00. This takes priority over everything else. `linha_idx` is cleared and `quadro` is held.
- Frame boundary: the 6→0 wrap, or OFF exit. At a boundary `frame_start` pulses and frame updates apply.
- Manual (01): `press` sets `pending`. At the boundary, if `pending` is set, `quadro` increments (7→0) and `pending` clears. Multiple presses within one frame produce a single step. A press on the boundary cycle itself is held for the next boundary.
- Auto (10/11): a refresh-frame counter increments at each boundary. When it reaches `AUTO_FRAMES`, `quadro` steps +1 (10) or −1 (11) with wrap, and the counter clears. `press` is ignored.
- On any mode change, `pending` and the refresh-frame counter clear. In OFF, `press` is discarded.

## Timing
- `chaves` change to output change: 3 clock edges (2 synchronizer stages + registered outputs).
- Debounce: `press` occurs `DEBOUNCE_TICKS`+3 cycles after `botao_n` settles low.
- All outputs are registered. No combinational path exists from input to output.
- Row slot is exactly `ROW_TICKS` cycles: `BLANK_TICKS` blank, then `ROW_TICKS`−`BLANK_TICKS` lit. A frame is 7×`ROW_TICKS` cycles.
- `quadro` changes only on a `frame_start` cycle, which is inside BLANK. Columns are therefore never lit during a frame change.
- `reset_n` asserted mid-slot forces all reset values immediately (asynchronous). The first boundary after release is OFF exit.

## Structure
- Package `matrix_pkg`: `NUM_ROWS`=7, `NUM_COLS`=5, mode encodings (`MODE_OFF`, `MODE_MANUAL`, `MODE_AUTO_FWD`, `MODE_AUTO_REV`), FSM state enum {OFF, BLANK, SCAN}.
- Sub-module `botao_debounce`: 2-FF synchronizer, stability counter (`DEBOUNCE_TICKS`), falling-edge `press` pulse.
- Top level contains the mode synchronizer, FSM, tick/row counters, frame logic, and output registers.

## Test plan
Parameters: `ROW_TICKS`=10, `BLANK_TICKS`=2, `DEBOUNCE_TICKS`=4, `AUTO_FRAMES`=3.
- Reset release with `chaves`=01 → `frame_start` pulses once. `linhas` is 7'h7F for 2 cycles, then 7'h7E for 8 cycles. `linha_idx` steps 0..6 with period 10, and `frame_start` repeats every 70 cycles.
- Manual mode, two clean presses within one frame → `quadro` goes 0→1 at the next `frame_start` only. No change at the following boundary.
- Bounce pulses on `botao_n` shorter than 4 cycles → no `press`, and `quadro` is unchanged.
- `chaves`=10 → `quadro` steps every 3 frames (210 cycles): 0,1,…,7,0. With `chaves`=11 from 0 → 7,6,….
- `chaves`→00 mid-SCAN on row 4 → 3 edges later `linhas`=7'h7F, `colunas_en`=0, `linha_idx`=0, `quadro` held. Return to 01 → restart at row 0 with `frame_start`.
- `reset_n` pulsed low mid-SCAN → all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared constants, mode encodings and FSM state type for the LED matrix scan sequencer.
package matrix_pkg;

   localparam int NUM_ROWS = 7;
   localparam int NUM_COLS = 5;

   localparam logic [1:0] MODE_OFF      = 2'b00;
   localparam logic [1:0] MODE_MANUAL   = 2'b01;
   localparam logic [1:0] MODE_AUTO_FWD = 2'b10;
   localparam logic [1:0] MODE_AUTO_REV = 2'b11;

   typedef enum logic [1:0] {
      ST_OFF   = 2'd0,
      ST_BLANK = 2'd1,
      ST_SCAN  = 2'd2
   } state_t;

   // Active-low one-hot row enable for the given row index.
   function automatic logic [NUM_ROWS-1:0] row_mask(input logic [2:0] idx);
      row_mask = ~(NUM_ROWS'(1) << idx);
   endfunction

endpackage

// File: rtl/matrix_scan_controller_if.sv
// Display-side bundle: row lines, row/frame indices to the column mux, column gate and FSM state.
interface matrix_if;

   logic [6:0]          linhas;
   logic [2:0]          linha_idx;
   logic [2:0]          quadro;
   logic                colunas_en;
   logic                frame_start;
   matrix_pkg::state_t  estado;

   modport master (
      output linhas, linha_idx, quadro, colunas_en, frame_start, estado
   );

   modport slave (
      input linhas, linha_idx, quadro, colunas_en, frame_start, estado
   );

endinterface

// File: rtl/matrix_scan_controller_botao_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter, one-cycle pulse on accepted press.
module botao_debounce #(
   parameter int DEBOUNCE_TICKS = 500000
) (
   input  logic clock_50MHz,
   input  logic reset_n,
   input  logic botao_n,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

   logic             b_m;
   logic             b_s;
   logic             nivel;
   logic [CNT_W-1:0] cnt;

   // The released (high) level is the idle state, so the synchronizer and accepted level reset high.
   always_ff @(posedge clock_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         b_m   <= 1'b1;
         b_s   <= 1'b1;
         nivel <= 1'b1;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         b_m   <= botao_n;
         b_s   <= b_m;
         press <= 1'b0;
         if (b_s == nivel) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt   <= '0;
            nivel <= b_s;
            press <= ~b_s;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/matrix_scan_controller.sv
// Row-scan sequencer for the 7x5 LED matrix: blanked row slots, frame index owned here,
// frame changes applied only at frame boundaries (row 6 -> 0 wrap or exit from OFF).
module matrix_scan_controller
   import matrix_pkg::*;
#(
   parameter int ROW_TICKS      = 50000,
   parameter int BLANK_TICKS    = 500,
   parameter int DEBOUNCE_TICKS = 500000,
   parameter int AUTO_FRAMES    = 60
) (
   input  logic       clock_50MHz,
   input  logic       reset_n,
   input  logic [1:0] chaves,
   input  logic       botao_n,
   matrix_if.master   disp
);

   localparam int TICK_W = $clog2(ROW_TICKS);
   localparam int FCNT_W = $clog2(AUTO_FRAMES + 1);
   localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
   localparam logic [TICK_W-1:0] ROW_LAST   = TICK_W'(ROW_TICKS - 1);
   localparam logic [FCNT_W-1:0] AUTO_LAST  = FCNT_W'(AUTO_FRAMES - 1);
   localparam logic [2:0]        LAST_ROW   = 3'(NUM_ROWS - 1);

   logic [1:0] chaves_m, mode_s, mode_q;
   logic       press;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [2:0]          row_q, row_d;
   logic [2:0]          quadro_q, quadro_d;
   logic                pending_q, pending_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic [NUM_ROWS-1:0] linhas_q, linhas_d;
   logic                colen_q, colen_d;
   logic                fstart_q;
   logic                boundary, mode_chg, pend_base;
   logic [FCNT_W-1:0]   fcnt_base;

   botao_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_debounce (
      .clock_50MHz (clock_50MHz),
      .reset_n     (reset_n),
      .botao_n     (botao_n),
      .press       (press)
   );

   always_ff @(posedge clock_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         chaves_m <= MODE_OFF;
         mode_s   <= MODE_OFF;
         mode_q   <= MODE_OFF;
      end else begin
         chaves_m <= chaves;
         mode_s   <= chaves_m;
         mode_q   <= mode_s;
      end
   end

   assign mode_chg = (mode_s != mode_q);

   // Slot timing: tick 0..BLANK_TICKS-1 is blank, the rest of the slot is lit.
   always_comb begin
      state_d  = state_q;
      tick_d   = tick_q + TICK_W'(1);
      row_d    = row_q;
      boundary = 1'b0;
      if (mode_s == MODE_OFF) begin
         state_d = ST_OFF;
         tick_d  = '0;
         row_d   = '0;
      end else begin
         case (state_q)
            ST_OFF: begin
               state_d  = ST_BLANK;
               tick_d   = '0;
               row_d    = '0;
               boundary = 1'b1;
            end
            ST_BLANK: begin
               if (tick_q == BLANK_LAST) state_d = ST_SCAN;
            end
            ST_SCAN: begin
               if (tick_q == ROW_LAST) begin
                  state_d = ST_BLANK;
                  tick_d  = '0;
                  if (row_q == LAST_ROW) begin
                     row_d    = '0;
                     boundary = 1'b1;
                  end else begin
                     row_d = row_q + 3'd1;
                  end
               end
            end
            default: begin
               state_d = ST_OFF;
               tick_d  = '0;
               row_d   = '0;
            end
         endcase
      end
   end

   // Frame update uses the pre-press pending value, so a press on the boundary cycle waits a frame.
   always_comb begin
      pend_base = mode_chg ? 1'b0 : pending_q;
      fcnt_base = mode_chg ? '0 : fcnt_q;
      pending_d = pend_base;
      fcnt_d    = fcnt_base;
      quadro_d  = quadro_q;
      if (boundary) begin
         if (mode_s == MODE_MANUAL && pend_base) begin
            quadro_d  = quadro_q + 3'd1;
            pending_d = 1'b0;
         end
         if (mode_s == MODE_AUTO_FWD || mode_s == MODE_AUTO_REV) begin
            if (fcnt_base == AUTO_LAST) begin
               fcnt_d   = '0;
               quadro_d = (mode_s == MODE_AUTO_REV) ? quadro_q - 3'd1 : quadro_q + 3'd1;
            end else begin
               fcnt_d = fcnt_base + FCNT_W'(1);
            end
         end
      end
      if (mode_s == MODE_MANUAL && press) pending_d = 1'b1;
   end

   always_comb begin
      linhas_d = (state_d == ST_SCAN) ? row_mask(row_d) : {NUM_ROWS{1'b1}};
      colen_d  = (state_d == ST_SCAN);
   end

   always_ff @(posedge clock_50MHz or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_OFF;
         tick_q    <= '0;
         row_q     <= '0;
         quadro_q  <= '0;
         pending_q <= 1'b0;
         fcnt_q    <= '0;
         linhas_q  <= {NUM_ROWS{1'b1}};
         colen_q   <= 1'b0;
         fstart_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         row_q     <= row_d;
         quadro_q  <= quadro_d;
         pending_q <= pending_d;
         fcnt_q    <= fcnt_d;
         linhas_q  <= linhas_d;
         colen_q   <= colen_d;
         fstart_q  <= boundary;
      end
   end

   assign disp.linhas      = linhas_q;
   assign disp.linha_idx   = row_q;
   assign disp.quadro      = quadro_q;
   assign disp.colunas_en  = colen_q;
   assign disp.frame_start = fstart_q;
   assign disp.estado      = state_q;

endmodule
